ce_reset_sequencer: RTL and testbench

//  Multi-channel clock-enable generator plus staged reset sequencer for the CPU/peripheral harnesses.

---
 rtl/ce_rst_pkg.sv | 25 ++
 rtl/ce_div_channel.sv | 65 ++++++
 rtl/ce_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_ce_reset_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_rst_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
// Holds the sequencer state encoding and the seq counter sizing function.
package ce_rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_STAGGER,
    S_RUN
  } seq_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RST_HOLD    = 32;
  localparam int DEF_RST_STAGGER = 8;
  localparam int DEF_WDOG_CYCLES = 65536;

  function automatic int seq_width(
    input int hold,
    input int ch,
    input int stagger
  );
    return $clog2(hold + ch * stagger + 1);
  endfunction

endpackage

// File: rtl/ce_div_channel.sv
// One runtime-programmable clock-enable divider channel.
// Divisor is latched on wrap so mid-period writes never shorten a period.
module ce_div_channel #(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [CNT_W-1:0] div_i,
  input  logic             en_i,
  output logic             ce_o,
  output logic             clk_log_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] eff_div;
  logic             init_q;
  logic             ce_q, ce_d;
  logic             clk_q, clk_d;
  logic             short_div;
  logic             wrap;

  // First cycle out of reset takes the divisor straight from the port.
  always_comb begin
    eff_div   = init_q ? div_i : div_q;
    short_div = (eff_div <= CNT_W'(1));
    wrap      = short_div ||
                (cnt_q == eff_div - CNT_W'(1));
    cnt_d     = cnt_q;
    div_d     = eff_div;
    ce_d      = 1'b0;
    clk_d     = clk_q;
    if (en_i) begin
      ce_d  = wrap;
      clk_d = !short_div &&
              (cnt_q < (eff_div >> 1));
      if (wrap) begin
        cnt_d = '0;
        div_d = div_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q  <= '0;
      div_q  <= '0;
      init_q <= 1'b1;
      ce_q   <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      init_q <= 1'b0;
      ce_q   <= ce_d;
      clk_q  <= clk_d;
    end
  end

  assign ce_o      = ce_q;
  assign clk_log_o = clk_q;

endmodule

// File: rtl/ce_reset_sequencer.sv
// Multi-channel clock-enable generator with staged reset release.
// Optional watchdog built when CE_RST_WDOG_EN is defined.
module ce_reset_sequencer
  import ce_rst_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int RST_STAGGER = DEF_RST_STAGGER,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    sw_rst_i,
  input  logic                    kick_i,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [NUM_CH-1:0]       clk_log_o,
  output logic [NUM_CH-1:0]       rstn_o,
  output logic                    ready_o,
  output logic                    wdog_o
);

  localparam int SEQ_W =
    seq_width(RST_HOLD, NUM_CH, RST_STAGGER);
  localparam int LAST =
    RST_HOLD + (NUM_CH - 1) * RST_STAGGER;

  seq_state_t        state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [NUM_CH-1:0] rstn_q, rstn_d;
  logic              ready_q, ready_d;
  logic              wd_fire;
  logic              rst_req;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ce_div_channel #(
      .CNT_W (CNT_W)
    ) u_div (
      .aclk      (aclk),
      .areset    (areset),
      .div_i     (div_i[g*CNT_W +: CNT_W]),
      .en_i      (en_i[g]),
      .ce_o      (ce_o[g]),
      .clk_log_o (clk_log_o[g])
    );
  end

  assign rst_req = sw_rst_i | wd_fire;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    rstn_d  = rstn_q;
    unique case (state_q)
      S_HOLD: begin
        rstn_d = '0;
        seq_d  = seq_q + SEQ_W'(1);
        if (seq_q == SEQ_W'(RST_HOLD - 1))
          state_d = S_STAGGER;
      end
      S_STAGGER: begin
        seq_d = seq_q + SEQ_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
          if (seq_q ==
              SEQ_W'(RST_HOLD + i * RST_STAGGER))
            rstn_d[i] = 1'b1;
        end
        if (seq_q == SEQ_W'(LAST))
          state_d = S_RUN;
      end
      S_RUN: begin
        seq_d = seq_q;
      end
      default: begin
        state_d = S_HOLD;
        seq_d   = '0;
        rstn_d  = '0;
      end
    endcase
    // A restart request overrides any release due this cycle.
    if (rst_req) begin
      state_d = S_HOLD;
      seq_d   = '0;
      rstn_d  = '0;
    end
    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_HOLD;
      seq_q   <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
    end
  end

  assign rstn_o  = rstn_q;
  assign ready_o = ready_q;

`ifdef CE_RST_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wcnt_q, wcnt_d;
  logic            wdog_q, wdog_d;

  always_comb begin
    wd_fire = (state_q == S_RUN) &&
              (wcnt_q == WD_W'(WDOG_CYCLES - 1));
    wcnt_d  = '0;
    if ((state_q == S_RUN) && !wd_fire)
      wcnt_d = kick_i ? '0 : wcnt_q + WD_W'(1);
    wdog_d  = wd_fire;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog_o = wdog_q;
`else
  logic unused_wdog;

  assign wd_fire     = 1'b0;
  assign wdog_o      = 1'b0;
  assign unused_wdog = kick_i ^ (WDOG_CYCLES == 0);
`endif

endmodule

// File: tb/tb_ce_reset_sequencer.sv
// Randomised self-checking bench for ce_reset_sequencer.
// Reference model tracks period position and time since sequence start.
module tb_ce_reset_sequencer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int HOLD   = 32;
  localparam int STAG   = 8;
  localparam int WD     = 100;
  localparam int REL0   = HOLD + 1;
  localparam int RUN_T  = HOLD + 1 + (NUM_CH - 1) * STAG;

  logic aclk     = 1'b0;
  logic areset   = 1'b1;
  logic sw_rst_i = 1'b0;
  logic kick_i   = 1'b0;
  logic [NUM_CH*CNT_W-1:0] div_i = '0;
  logic [NUM_CH-1:0]       en_i  = '0;
  logic [NUM_CH-1:0] ce_o, clk_log_o, rstn_o;
  logic ready_o, wdog_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [NUM_CH-1:0] exp_ce, exp_clk, exp_rstn;
  logic exp_ready, exp_wdog;
  int   ph   [NUM_CH];
  int   plen [NUM_CH];
  int   seq_t, idle;
  bit   first;

  ce_reset_sequencer #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .RST_HOLD    (HOLD),
    .RST_STAGGER (STAG),
    .WDOG_CYCLES (WD)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .div_i     (div_i),
    .en_i      (en_i),
    .sw_rst_i  (sw_rst_i),
    .kick_i    (kick_i),
    .ce_o      (ce_o),
    .clk_log_o (clk_log_o),
    .rstn_o    (rstn_o),
    .ready_o   (ready_o),
    .wdog_o    (wdog_o)
  );

  always #5 aclk = ~aclk;

  function automatic int cur_div(int c);
    return int'(div_i[c*CNT_W +: CNT_W]);
  endfunction

  task automatic set_div(int c, int d);
    div_i[c*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      ph[c]   = 0;
      plen[c] = 0;
    end
    first = 1; seq_t = 0; idle = 0;
    exp_ce = '0; exp_clk = '0; exp_rstn = '0;
    exp_ready = 0; exp_wdog = 0;
  endtask

  // Outputs seen after an edge reflect the cycle that edge closed.
  task automatic model_step();
    bit fire;
    fire = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (first) plen[c] = cur_div(c);
      if (!en_i[c]) begin
        exp_ce[c] = 1'b0;
      end else if (plen[c] <= 1) begin
        exp_ce[c] = 1'b1; exp_clk[c] = 1'b0;
        ph[c] = 0; plen[c] = cur_div(c);
      end else begin
        exp_ce[c]  = (ph[c] == plen[c] - 1);
        exp_clk[c] = (ph[c] < plen[c] / 2);
        ph[c] = (ph[c] + 1) % plen[c];
        if (ph[c] == 0) plen[c] = cur_div(c);
      end
    end
    first = 0;
`ifdef CE_RST_WDOG_EN
    if (seq_t >= RUN_T) begin
      if (idle == WD - 1) fire = 1;
      else if (kick_i)    idle = 0;
      else                idle++;
    end else begin
      idle = 0;
    end
`endif
    if (sw_rst_i || fire) begin
      seq_t = 0; idle = 0;
    end else begin
      seq_t++;
    end
    exp_wdog = fire;
    for (int i = 0; i < NUM_CH; i++)
      exp_rstn[i] = (seq_t >= REL0 + i * STAG);
    exp_ready = (seq_t >= RUN_T);
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    areset = 1'b1; sw_rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ce_o, clk_log_o, rstn_o, ready_o, wdog_o} !== 14'b0) begin
      errors++;
      $display("FAIL reset_values got=%h exp=0",
        {ce_o, clk_log_o, rstn_o, ready_o, wdog_o});
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    int rel [NUM_CH];
    int rdy, nce, nhi;
    for (int c = 0; c < NUM_CH; c++) set_div(c, 16);
    en_i = '1;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) rel[c] = -1;
    rdy = -1; nce = 0; nhi = 0;
    for (int n = 0; n < 140; n++) begin
      tick();
      checks++;
      if ({ce_o, clk_log_o, rstn_o, ready_o, wdog_o} !==
          {exp_ce, exp_clk, exp_rstn, exp_ready, exp_wdog}) begin
        errors++;
        $display("FAIL reset_seq cyc=%0d got=%h exp=%h", cyc,
          {ce_o, clk_log_o, rstn_o, ready_o, wdog_o},
          {exp_ce, exp_clk, exp_rstn, exp_ready, exp_wdog});
      end
      for (int c = 0; c < NUM_CH; c++)
        if (rstn_o[c] && rel[c] < 0) rel[c] = cyc;
      if (ready_o && rdy < 0) rdy = cyc;
      nce += int'(ce_o[0]);
      nhi += int'(clk_log_o[0]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (rel[c] !== REL0 + c * STAG) begin
        errors++;
        $display("FAIL release_ch%0d got=%0d exp=%0d",
          c, rel[c], REL0 + c * STAG);
      end
    end
    checks++;
    if (rdy !== RUN_T) begin
      errors++;
      $display("FAIL ready_time got=%0d exp=%0d", rdy, RUN_T);
    end
    checks++;
    if (nce !== 8 || nhi !== 72) begin
      errors++;
      $display("FAIL div16_cadence ce=%0d hi=%0d exp 8/72", nce, nhi);
    end
  endtask

  task automatic test_div_change();
    int pul[$];
    logic hist [40];
    int t0, hi;
    for (int n = 0; n < 40 && ph[0] != 3; n++) tick();
    checks++;
    if (ph[0] != 3) begin
      errors++;
      $display("FAIL div_change_sync ph=%0d exp=3", ph[0]);
    end
    set_div(0, 5);
    t0 = cyc;
    for (int n = 0; n < 40; n++) begin
      tick();
      checks++;
      if ({ce_o, clk_log_o} !== {exp_ce, exp_clk}) begin
        errors++;
        $display("FAIL div_change cyc=%0d got=%h exp=%h", cyc,
          {ce_o, clk_log_o}, {exp_ce, exp_clk});
      end
      hist[n] = clk_log_o[0];
      if (ce_o[0]) pul.push_back(cyc - t0);
    end
    checks++;
    if (pul.size() < 4 || pul[0] != 13 || pul[1] != 18 ||
        pul[2] != 23 || pul[3] != 28) begin
      errors++;
      $display("FAIL div_change_pulses got=%p exp=13,18,23,28", pul);
    end else begin
      hi = 0;
      for (int k = pul[1]; k < pul[2]; k++) hi += int'(hist[k-1]);
      checks++;
      if (hi !== 2) begin
        errors++;
        $display("FAIL div5_high got=%0d exp=2", hi);
      end
    end
  endtask

  task automatic test_div01();
    logic held;
    int   n0;
    set_div(1, 0);
    set_div(2, 1);
    for (int n = 0; n < 24; n++) tick();
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if ({ce_o[2:1], clk_log_o[2:1]} !== 4'b1100) begin
        errors++;
        $display("FAIL div01 cyc=%0d got=%b exp=1100", cyc,
          {ce_o[2:1], clk_log_o[2:1]});
      end
    end
    held = clk_log_o[0];
    en_i[1:0] = 2'b00;
    n0 = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      n0 += int'(ce_o[0]) + int'(ce_o[1]);
      checks++;
      if (clk_log_o[0] !== held || ce_o !== exp_ce) begin
        errors++;
        $display("FAIL en_freeze cyc=%0d ce=%b clk0=%b exp ce=%b clk0=%b",
          cyc, ce_o, clk_log_o[0], exp_ce, held);
      end
    end
    checks++;
    if (n0 !== 0) begin
      errors++;
      $display("FAIL en_off_pulses got=%0d exp=0", n0);
    end
    en_i = '1;
    for (int n = 0; n < 30; n++) begin
      tick();
      checks++;
      if ({ce_o, clk_log_o} !== {exp_ce, exp_clk}) begin
        errors++;
        $display("FAIL en_resume cyc=%0d got=%h exp=%h", cyc,
          {ce_o, clk_log_o}, {exp_ce, exp_clk});
      end
    end
  endtask

  task automatic test_sw_rst_run();
    int rel [NUM_CH];
    int rdy;
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    cyc = 0;
    checks++;
    if ({rstn_o, ready_o} !== 5'b0) begin
      errors++;
      $display("FAIL sw_rst_clear got=%b exp=00000", {rstn_o, ready_o});
    end
    for (int c = 0; c < NUM_CH; c++) rel[c] = -1;
    rdy = -1;
    for (int n = 0; n < 70; n++) begin
      tick();
      checks++;
      if ({ce_o, clk_log_o, rstn_o, ready_o, wdog_o} !==
          {exp_ce, exp_clk, exp_rstn, exp_ready, exp_wdog}) begin
        errors++;
        $display("FAIL sw_rst_seq cyc=%0d got=%h exp=%h", cyc,
          {ce_o, clk_log_o, rstn_o, ready_o, wdog_o},
          {exp_ce, exp_clk, exp_rstn, exp_ready, exp_wdog});
      end
      for (int c = 0; c < NUM_CH; c++)
        if (rstn_o[c] && rel[c] < 0) rel[c] = cyc;
      if (ready_o && rdy < 0) rdy = cyc;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (rel[c] !== REL0 + c * STAG) begin
        errors++;
        $display("FAIL sw_release_ch%0d got=%0d exp=%0d",
          c, rel[c], REL0 + c * STAG);
      end
    end
    checks++;
    if (rdy !== RUN_T) begin
      errors++;
      $display("FAIL sw_ready_time got=%0d exp=%0d", rdy, RUN_T);
    end
  endtask

  task automatic test_sw_rst_collide();
    int rel2;
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    for (int n = 0; n < 60 && seq_t != REL0 + 2 * STAG - 1; n++)
      tick();
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    cyc = 0;
    checks++;
    if ({rstn_o, ready_o} !== 5'b0) begin
      errors++;
      $display("FAIL collide_clear got=%b exp=00000", {rstn_o, ready_o});
    end
    rel2 = -1;
    for (int n = 0; n < 60; n++) begin
      tick();
      checks++;
      if ({rstn_o, ready_o} !== {exp_rstn, exp_ready}) begin
        errors++;
        $display("FAIL collide_seq cyc=%0d got=%b exp=%b", cyc,
          {rstn_o, ready_o}, {exp_rstn, exp_ready});
      end
      if (rstn_o[2] && rel2 < 0) rel2 = cyc;
    end
    checks++;
    if (rel2 !== REL0 + 2 * STAG) begin
      errors++;
      $display("FAIL collide_rel2 got=%0d exp=%0d", rel2, REL0 + 2 * STAG);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0)
        set_div(int'($urandom_range(0, NUM_CH - 1)),
                int'($urandom_range(0, 12)));
      if ($urandom_range(0, 7) == 0)
        en_i = NUM_CH'($urandom);
      sw_rst_i = ($urandom_range(0, 299) == 0);
      kick_i   = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({ce_o, clk_log_o, rstn_o, ready_o, wdog_o} !==
          {exp_ce, exp_clk, exp_rstn, exp_ready, exp_wdog}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
          {ce_o, clk_log_o, rstn_o, ready_o, wdog_o},
          {exp_ce, exp_clk, exp_rstn, exp_ready, exp_wdog});
      end
    end
    sw_rst_i = 1'b0;
    kick_i   = 1'b0;
    en_i     = '1;
  endtask

  task automatic test_wdog();
    int fire_at, exp_at, nw;
`ifdef CE_RST_WDOG_EN
    exp_at = RUN_T + WD;
`else
    exp_at = -1;
`endif
    kick_i = 1'b0;
    do_reset();
    fire_at = -1;
    for (int n = 0; n < 250; n++) begin
      tick();
      checks++;
      if ({rstn_o, ready_o, wdog_o} !==
          {exp_rstn, exp_ready, exp_wdog}) begin
        errors++;
        $display("FAIL wdog_idle cyc=%0d got=%b exp=%b", cyc,
          {rstn_o, ready_o, wdog_o}, {exp_rstn, exp_ready, exp_wdog});
      end
      if (wdog_o && fire_at < 0) begin
        fire_at = cyc;
        checks++;
        if ({rstn_o, ready_o} !== 5'b0) begin
          errors++;
          $display("FAIL wdog_rerun got=%b exp=00000", {rstn_o, ready_o});
        end
      end
    end
    checks++;
    if (fire_at !== exp_at) begin
      errors++;
      $display("FAIL wdog_time got=%0d exp=%0d", fire_at, exp_at);
    end
    nw = 0;
    for (int n = 0; n < 400; n++) begin
      kick_i = (n % 50 == 0);
      tick();
      nw += int'(wdog_o);
      checks++;
      if ({rstn_o, ready_o, wdog_o} !==
          {exp_rstn, exp_ready, exp_wdog}) begin
        errors++;
        $display("FAIL wdog_kick cyc=%0d got=%b exp=%b", cyc,
          {rstn_o, ready_o, wdog_o}, {exp_rstn, exp_ready, exp_wdog});
      end
    end
    kick_i = 1'b0;
    checks++;
    if (nw !== 0) begin
      errors++;
      $display("FAIL wdog_kicked_pulses got=%0d exp=0", nw);
    end
  endtask

  initial begin
    test_reset();
    test_div_change();
    test_div01();
    test_sw_rst_run();
    test_sw_rst_collide();
    test_random();
    test_wdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
